// File: rtl/display_scan_controller.sv
// Multiplexed 4-digit BCD scan controller. A loaded value is staged in a
// pending register and only swapped into the display at a frame boundary.
module display_scan_controller #(
  parameter int unsigned CLK_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        blank_lz,
  output logic        ready,
  output logic [3:0]  bch,
  output logic [3:0]  digit_en
);

  localparam logic [15:0] TICK_MAX = 16'(CLK_DIV - 1);

  logic [15:0] tick_q, tick_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] shown_q, shown_d;
  logic [15:0] pend_val_q, pend_val_d;
  logic        pend_q, pend_d;
  logic        tick_wrap, frame_end, accept;
  logic [3:0]  blank;

  always_comb begin
    tick_wrap  = en && (tick_q == TICK_MAX);
    frame_end  = tick_wrap && (idx_q == 2'd3);
    accept     = load && !pend_q;
    tick_d     = tick_q;
    idx_d      = idx_q;
    shown_d    = shown_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    if (en) begin
      tick_d = tick_wrap ? 16'd0 : tick_q + 16'd1;
      if (tick_wrap) idx_d = idx_q + 2'd1;
    end
    // The display only ever changes here, so a frame is never mixed.
    if (frame_end) begin
      if (pend_q) begin
        shown_d = pend_val_q;
        pend_d  = 1'b0;
      end else if (accept) begin
        shown_d = value;
      end
    end else if (accept) begin
      pend_val_d = value;
      pend_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q     <= '0;
      idx_q      <= '0;
      shown_q    <= '0;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
    end else begin
      tick_q     <= tick_d;
      idx_q      <= idx_d;
      shown_q    <= shown_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
    end
  end

  // Leading-zero blanking cascades down from digit 3; digit 0 always shows.
  always_comb begin
    blank[3] = blank_lz && (shown_q[15:12] == 4'h0);
    blank[2] = blank[3] && (shown_q[11:8] == 4'h0);
    blank[1] = blank[2] && (shown_q[7:4] == 4'h0);
    blank[0] = 1'b0;
  end

  assign ready    = !pend_q;
  assign bch      = blank[idx_q] ? 4'hF : shown_q[{idx_q, 2'b00} +: 4];
  assign digit_en = en ? (4'b0001 << idx_q) : 4'b0000;

endmodule

// File: tb/tb_display_scan_controller.sv
// Scoreboard bench: stimulus pushes expected outputs from a frame-level model,
// a negedge monitor pops and compares against the DUT.
module tb_display_scan_controller;
  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst, en, load, blank_lz;
  logic [15:0] value;
  logic        ready;
  logic [3:0]  bch, digit_en;

  always #5 clk = ~clk;

  display_scan_controller #(.CLK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .value(value),
    .blank_lz(blank_lz), .ready(ready), .bch(bch), .digit_en(digit_en)
  );

  typedef struct packed {
    logic       r;
    logic [3:0] b;
    logic [3:0] d;
  } exp_t;

  exp_t expq[$];
  exp_t got_e;
  int   n_chk = 0;
  int   n_err = 0;

  // Model: position within a frame counted in enabled cycles.
  int          ecnt;
  logic [15:0] m_shown;
  logic [15:0] m_pend[$];

  function automatic exp_t expect_now();
    exp_t x;
    int k;
    logic [15:0] upper;
    k     = ecnt / DIV;
    upper = m_shown >> (4 * k);
    x.r   = (m_pend.size() == 0);
    x.d   = en ? 4'(1 << k) : 4'b0000;
    x.b   = (blank_lz && k > 0 && upper == 16'h0) ? 4'hF : upper[3:0];
    return x;
  endfunction

  task automatic step(input logic r, input logic e, input logic l,
                      input logic [15:0] v, input logic bl);
    logic bnd;
    rst = r; en = e; load = l; value = v; blank_lz = bl;
    if (r) begin
      ecnt = 0; m_shown = 16'h0; m_pend.delete();
    end
    expq.push_back(expect_now());
    @(posedge clk);
    if (!r) begin
      bnd = e && (ecnt == FRAME - 1);
      if (bnd) begin
        if (m_pend.size() != 0) m_shown = m_pend.pop_front();
        else if (l) m_shown = v;
      end else if (l && m_pend.size() == 0) begin
        m_pend.push_back(v);
      end
      if (e) ecnt = (ecnt + 1) % FRAME;
    end
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      got_e = expq.pop_front();
      check("ready", {3'b0, ready}, {3'b0, got_e.r});
      check("digit_en", digit_en, got_e.d);
      check("bch", bch, got_e.b);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; value = 16'h0; blank_lz = 1'b0;
    ecnt = 0; m_shown = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state with scan enabled.
    step(1, 1, 0, 16'h0, 0);
    step(1, 1, 0, 16'h0, 0);
    // Free-running scan: each digit held DIV cycles.
    repeat (FRAME + 5) step(0, 1, 0, 16'h0, 0);
    // Mid-frame load, then an ignored second load.
    step(0, 1, 1, 16'h1234, 0);
    step(0, 1, 1, 16'h9999, 0);
    repeat (2 * FRAME) step(0, 1, 0, 16'h0, 0);
    // Leading-zero blanking patterns.
    step(0, 1, 1, 16'h0070, 1);
    repeat (2 * FRAME) step(0, 1, 0, 16'h0, 1);
    repeat (FRAME) step(0, 1, 0, 16'h0, 0);
    step(0, 1, 1, 16'h0000, 1);
    repeat (2 * FRAME) step(0, 1, 0, 16'h0, 1);
    // Load exactly on the boundary edge goes straight to the display.
    while (ecnt != FRAME - 1) step(0, 1, 0, 16'h0, 1);
    step(0, 1, 1, 16'h5678, 1);
    repeat (FRAME) step(0, 1, 0, 16'h0, 1);
    // Pause mid-frame and resume on the same digit.
    repeat (6) step(0, 1, 0, 16'h0, 0);
    repeat (5) step(0, 0, 0, 16'h0, 0);
    repeat (FRAME) step(0, 1, 0, 16'h0, 0);
    // Reset while a value is pending discards it.
    while (ecnt == FRAME - 1) step(0, 1, 0, 16'h0, 0);
    step(0, 1, 1, 16'hABCD, 0);
    step(0, 1, 0, 16'h0, 0);
    step(1, 1, 0, 16'h0, 0);
    repeat (2 * FRAME) step(0, 1, 0, 16'h0, 0);
    // Randomized traffic.
    repeat (3000)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 3) == 0, 16'($urandom), 1'($urandom_range(0, 1)));
    repeat (2) @(negedge clk);
    n_chk++;
    if (expq.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d entries left expected 0", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
